instruction_fetch: RTL and testbench

// Fetch stage upstream of the decode stage. Holds the PC, issues word reads to instruction memory and

---
 rtl/instruction_fetch.sv | 94 +++++++++
 tb/tb_instruction_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: issues word reads from fetch_pc, tags them in a PC FIFO and queues {pc, inst} for decode.
// Branch redirects flush the queue and drop responses still owed from the old path via a kill count.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic          r_run;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_inflight, r_kill, r_occ;
  logic [PW-1:0] r_tag_wr, r_tag_rd, r_q_wr, r_q_rd;
  logic [31:0]   r_tag    [DEPTH];
  logic [31:0]   r_q_pc   [DEPTH];
  logic [31:0]   r_q_inst [DEPTH];

  logic [CW:0]   w_used;
  logic          w_req, w_accept, w_resp, w_push, w_pop, w_empty;

  // r_run keeps the request port quiet for the first cycle out of reset.
  assign w_used   = {1'b0, r_inflight} + {1'b0, r_occ};
  assign w_req    = r_run && (w_used < (CW+1)'(DEPTH)) && !br_taken_i;
  assign w_accept = w_req && imem_req_ready_i;
  assign w_resp   = imem_resp_valid_i && (r_inflight != '0);
  assign w_push   = w_resp && (r_kill == '0) && !br_taken_i;
  assign w_empty  = (r_occ == '0);
  assign w_pop    = !w_empty && id_ready_i;

  assign imem_req_valid_o = w_req;
  assign imem_req_addr_o  = w_req ? r_fetch_pc : '0;
  assign id_valid_o       = !w_empty;
  assign id_pc_o          = w_empty ? '0 : r_q_pc[r_q_rd];
  assign id_inst_o        = w_empty ? '0 : r_q_inst[r_q_rd];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_kill     <= '0;
      r_occ      <= '0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_resp);
      if (w_accept) r_tag_wr <= r_tag_wr + PW'(1);
      if (w_resp)   r_tag_rd <= r_tag_rd + PW'(1);
      if (br_taken_i) begin
        // Everything still owed after this cycle's response belongs to the old path.
        r_fetch_pc <= {br_target_i[31:2], 2'b00};
        r_kill     <= r_inflight - CW'(w_resp);
        r_occ      <= '0;
        r_q_rd     <= r_q_wr;
      end else begin
        if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp && r_kill != '0) r_kill <= r_kill - CW'(1);
        r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        if (w_push) r_q_wr <= r_q_wr + PW'(1);
        if (w_pop)  r_q_rd <= r_q_rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) r_tag[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_q_wr]   <= r_tag[r_tag_rd];
      r_q_inst[r_q_wr] <= imem_resp_data_i;
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(imem_resp_valid_i && r_inflight == '0));
  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_used <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model plus a decode-side model that expects a
// sequential PC stream restarted at each redirect target.
module tb_instruction_fetch;
  localparam logic [31:0] RPC = 32'h1c00_0000;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        imem_req_valid_o, imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic        id_valid_o, id_ready_i = 1'b0;
  logic [31:0] id_pc_o, id_inst_o;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;

  instruction_fetch #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i));

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] cons_q[$];
  int          cons_c[$];
  int          cyc = 0, lat = 1, rdy_pct = 100, idr_pct = 100;
  int          n_tests = 0, n_fail = 0, n_acc = 0, first_acc = -1, first_vld = -1;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0, exp_pc = RPC;
  logic        s_req, s_idv, s_resp;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  // One clock: drive memory/decode/branch inputs, sample before the edge, update the models.
  task automatic cycle();
    pend_t p;
    imem_req_ready_i = ($urandom_range(99) < rdy_pct);
    id_ready_i       = ($urandom_range(99) < idr_pct);
    br_taken_i       = br;
    br_target_i      = br_tgt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid_i = 1'b1;
      imem_resp_data_i  = memf(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_resp_valid_i = 1'b0;
      imem_resp_data_i  = $urandom;
    end
    #1;
    s_req = imem_req_valid_o; s_addr = imem_req_addr_o; s_resp = imem_resp_valid_i;
    s_idv = id_valid_o; s_pc = id_pc_o; s_inst = id_inst_o;
    if (s_req && imem_req_ready_i) begin
      p.addr = s_addr; p.due = cyc + lat;
      pend.push_back(p);
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      n_tests++;
      if (s_addr[1:0] !== 2'b00) begin n_fail++; $display("FAIL req_align addr=%h", s_addr); end
    end
    if (br) begin
      n_tests++;
      if (s_req !== 1'b0) begin n_fail++; $display("FAIL req_during_branch got=%b want=0", s_req); end
    end
    if (s_idv && first_vld < 0) first_vld = cyc;
    if (s_idv && id_ready_i) begin
      n_tests++;
      if (s_pc !== exp_pc || s_inst !== memf(exp_pc)) begin
        n_fail++;
        $display("FAIL id_stream pc=%h inst=%h want pc=%h inst=%h", s_pc, s_inst, exp_pc, memf(exp_pc));
      end
      cons_q.push_back(s_pc); cons_c.push_back(cyc);
      exp_pc = exp_pc + 32'd4;
    end else if (!s_idv) begin
      n_tests++;
      if (s_pc !== '0 || s_inst !== '0) begin
        n_fail++; $display("FAIL id_zero_when_empty pc=%h inst=%h want 0", s_pc, s_inst);
      end
    end
    if (br) exp_pc = {br_tgt[31:2], 2'b00};
    @(posedge clk_i); cyc++; #1;
    br = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    pend.delete();
    imem_resp_valid_i = 1'b0; imem_req_ready_i = 1'b0; id_ready_i = 1'b0;
    br = 1'b0; br_taken_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    exp_pc = RPC; n_acc = 0; first_acc = -1; first_vld = -1;
    cons_q.delete(); cons_c.delete();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; #3;
    n_tests++;
    if (imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b0 || id_pc_o !== '0 || id_inst_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs req=%b idv=%b pc=%h inst=%h want all 0",
               imem_req_valid_o, id_valid_o, id_pc_o, id_inst_o);
    end
    do_reset();
    lat = 1; rdy_pct = 100; idr_pct = 100;
    for (int i = 0; i < 3 && first_acc < 0; i++) cycle();
    n_tests++;
    if (s_addr !== RPC) begin n_fail++; $display("FAIL first_req_addr got=%h want=%h", s_addr, RPC); end
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; rdy_pct = 100; idr_pct = 100;
    repeat (8) cycle();
    n_tests++;
    if (first_acc < 0 || first_vld - first_acc !== 2) begin
      n_fail++; $display("FAIL first_latency got=%0d want=2", first_vld - first_acc);
    end
    n_tests++;
    if (cons_q.size() < 3) begin
      n_fail++; $display("FAIL stream_count got=%0d want>=3", cons_q.size());
    end else if (cons_q[1] !== RPC + 32'd4 || cons_q[2] !== RPC + 32'd8 ||
                 cons_c[1] != cons_c[0] + 1 || cons_c[2] != cons_c[0] + 2) begin
      n_fail++; $display("FAIL zero_bubble pcs=%h,%h cycles=%0d,%0d,%0d",
                         cons_q[1], cons_q[2], cons_c[0], cons_c[1], cons_c[2]);
    end
  endtask

  task automatic test_full();
    do_reset();
    lat = 1; rdy_pct = 100; idr_pct = 0;
    repeat (10) cycle();
    n_tests++;
    if (n_acc !== 4) begin n_fail++; $display("FAIL full_accepts got=%0d want=4", n_acc); end
    n_tests++;
    if (imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b1 || id_pc_o !== RPC || id_inst_o !== memf(RPC)) begin
      n_fail++; $display("FAIL full_hold req=%b idv=%b pc=%h want req=0 idv=1 pc=%h",
                         imem_req_valid_o, id_valid_o, id_pc_o, RPC);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3; rdy_pct = 100; idr_pct = 0;
    for (int i = 0; i < 20 && n_acc < 3; i++) cycle();
    n_tests++;
    if (n_acc !== 3) begin n_fail++; $display("FAIL redir_setup accepts=%0d want=3", n_acc); end
    rdy_pct = 0; br = 1'b1; br_tgt = 32'h1c00_0101;
    cycle();
    cycle();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== 32'h1c00_0100) begin
      n_fail++; $display("FAIL redir_addr req=%b addr=%h want 1 1c000100", s_req, s_addr);
    end
    rdy_pct = 100; idr_pct = 100;
    repeat (15) cycle();
    n_tests++;
    if (cons_q.size() == 0 || cons_q[0] !== 32'h1c00_0100) begin
      n_fail++; $display("FAIL redir_first_pc got=%h want=1c000100", cons_q.size() ? cons_q[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_consume();
    do_reset();
    lat = 1; rdy_pct = 100; idr_pct = 100;
    repeat (6) cycle();
    br = 1'b1; br_tgt = 32'h1c00_0180;
    cycle();
    n_tests++;
    if (s_idv !== 1'b1 || s_resp !== 1'b1) begin
      n_fail++; $display("FAIL rc_setup idv=%b resp=%b want 1 1", s_idv, s_resp);
    end
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_tests++;
      if (s_idv !== 1'b0) begin n_fail++; $display("FAIL rc_flushed k=%0d idv=%b want=0", k, s_idv); end
    end
    cycle();
    n_tests++;
    if (s_idv !== 1'b1 || s_pc !== 32'h1c00_0180) begin
      n_fail++; $display("FAIL rc_target idv=%b pc=%h want 1 1c000180", s_idv, s_pc);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 2; rdy_pct = 100; idr_pct = 100;
    repeat (8) cycle();
    br = 1'b1; br_tgt = 32'h1c00_0200; cycle();
    br = 1'b1; br_tgt = 32'h1c00_0300; cycle();
    cons_q.delete();
    repeat (15) cycle();
    n_tests++;
    if (cons_q.size() == 0 || cons_q[0] !== 32'h1c00_0300) begin
      n_fail++; $display("FAIL b2b_first_pc got=%h want=1c000300", cons_q.size() ? cons_q[0] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 3; rdy_pct = 100; idr_pct = 100;
    repeat (2) cycle();
    for (int i = 0; i < 50 && pend.size() != 2; i++) cycle();
    n_tests++;
    if (pend.size() != 2) begin n_fail++; $display("FAIL rmid_setup inflight=%0d want=2", pend.size()); end
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if (imem_req_valid_o !== 1'b0 || id_valid_o !== 1'b0 || id_pc_o !== '0 || id_inst_o !== '0) begin
      n_fail++; $display("FAIL rmid_outputs req=%b idv=%b pc=%h want 0", imem_req_valid_o, id_valid_o, id_pc_o);
    end
    do_reset();
    lat = 1;
    repeat (10) cycle();
    n_tests++;
    if (cons_q.size() == 0 || cons_q[0] !== RPC) begin
      n_fail++; $display("FAIL rmid_restart got=%h want=%h", cons_q.size() ? cons_q[0] : 32'hx, RPC);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 3; run++) begin
      do_reset();
      lat = $urandom_range(1, 4); rdy_pct = 70; idr_pct = 60;
      repeat (300) begin
        if ($urandom_range(19) == 0) begin
          br = 1'b1;
          br_tgt = RPC | ($urandom & 32'h0000_fffc) | 32'($urandom_range(3));
        end
        cycle();
      end
      n_tests++;
      if (cons_q.size() < 20) begin n_fail++; $display("FAIL rand_progress run=%0d got=%0d want>=20", run, cons_q.size()); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_consume();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
